// File: rtl/polar_pkg.sv
// Shared constants, frame-count type and index helper for the polar encoder pipeline.
package polar_pkg;

  localparam int LOG_N_MAX = 10;
  localparam int CNT_W_DEF = 16;

  // Default-width counter type; instances with a non-default CNT_W declare their own.
  typedef logic [CNT_W_DEF-1:0] frame_cnt_t;

  // Reverse the low nbits of idx; used at elaboration to wire the reorder mux.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < LOG_N_MAX; b++) begin
      if (b < nbits) r = r | (((idx >> b) & 1) << (nbits - 1 - b));
    end
    return r;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One butterfly stage: XOR network with span 2**STAGE plus its data/valid/mode registers.
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter  int LOG_N = 2,
  parameter  int STAGE = 0,
  localparam int BITS  = 2**LOG_N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [BITS-1:0] v,
  input  logic            vld_in,
  input  logic            rev_in,
  output logic [BITS-1:0] y,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q,
  output logic            vld_q,
  output logic            rev_q
);

  localparam int H = 2**STAGE;

  // y is exposed so the owner can insert logic (the reorder mux) before the register.
  for (genvar i = 0; i < BITS; i++) begin : g_bf
    if (((i >> STAGE) & 1) == 0) begin : g_top
      assign y[i] = v[i] ^ v[i+H];
    end else begin : g_bot
      assign y[i] = v[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '0;
      vld_q <= 1'b0;
      rev_q <= 1'b0;
    end else if (en) begin
      q     <= d;
      vld_q <= vld_in;
      rev_q <= rev_in;
    end
  end

endmodule

// File: rtl/polar_transform_pipe.sv
// Pipelined polar encoder x = u*F^{(x)n}: one butterfly per register, valid/ready on both sides.
module polar_transform_pipe
  import polar_pkg::*;
#(
  parameter  int LOG_N = 2,
  parameter  int CNT_W = 16,
  localparam int BITS  = 2**LOG_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             u [BITS],
  input  logic             bit_rev,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             x [BITS],
  output logic [CNT_W-1:0] frame_cnt
);

  typedef logic [CNT_W-1:0] cnt_t;

  logic                       en;
  logic [LOG_N:0][BITS-1:0]   d_pipe;
  logic [LOG_N:0]             vld_pipe;
  logic [LOG_N:0]             rev_pipe;
  logic [LOG_N-1:0][BITS-1:0] y_comb;
  logic [LOG_N-1:0][BITS-1:0] y_load;
  logic                       rev_tail_unused;

  // Whole pipe advances together; in_ready is combinational from out_ready on purpose.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar i = 0; i < BITS; i++) begin : g_io
    assign d_pipe[0][i] = u[i];
    assign x[i]         = d_pipe[LOG_N][i];
  end

  assign vld_pipe[0]     = in_valid;
  assign rev_pipe[0]     = bit_rev;
  assign out_valid       = vld_pipe[LOG_N];
  assign rev_tail_unused = rev_pipe[LOG_N];

  for (genvar s = 0; s < LOG_N; s++) begin : g_stage
    polar_butterfly_stage #(
      .LOG_N (LOG_N),
      .STAGE (s)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .v      (d_pipe[s]),
      .vld_in (vld_pipe[s]),
      .rev_in (rev_pipe[s]),
      .y      (y_comb[s]),
      .d      (y_load[s]),
      .q      (d_pipe[s+1]),
      .vld_q  (vld_pipe[s+1]),
      .rev_q  (rev_pipe[s+1])
    );

    if (s == LOG_N-1) begin : g_last
      // Reorder sits in front of the final register, so it costs no cycle.
      logic [BITS-1:0] y_rev;
      for (genvar i = 0; i < BITS; i++) begin : g_rev
        localparam int unsigned RI = bitrev(i, LOG_N);
        assign y_rev[i] = y_comb[s][RI];
      end
      assign y_load[s] = rev_pipe[s] ? y_rev : y_comb[s];
    end else begin : g_mid
      assign y_load[s] = y_comb[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                       frame_cnt <= '0;
    else if (out_valid && out_ready)  frame_cnt <= frame_cnt + cnt_t'(1);
  end

endmodule

// File: tb/tb_polar_transform_pipe.sv
// Scoreboard bench: stimulus pushes expected codewords, a negedge monitor pops on each handshake.
module tb_polar_transform_pipe;

  localparam int N  = 4;
  localparam int N3 = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        bit_rev = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic        u [N];
  logic        x [N];
  logic [15:0] frame_cnt;

  logic        w_in_ready, w_out_valid;
  logic        w_x [N];
  logic [3:0]  w_cnt;

  logic        in_valid3 = 1'b0;
  logic        bit_rev3 = 1'b0;
  logic        out_ready3 = 1'b1;
  logic        in_ready3, out_valid3;
  logic        u3 [N3];
  logic        x3 [N3];
  logic [15:0] cnt3;

  always #5 clk = ~clk;

  polar_transform_pipe #(.LOG_N(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .u(u),
    .bit_rev(bit_rev), .out_valid(out_valid), .out_ready(out_ready), .x(x), .frame_cnt(frame_cnt));

  polar_transform_pipe #(.LOG_N(2), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .u(u),
    .bit_rev(bit_rev), .out_valid(w_out_valid), .out_ready(out_ready), .x(w_x), .frame_cnt(w_cnt));

  polar_transform_pipe #(.LOG_N(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .u(u3),
    .bit_rev(bit_rev3), .out_valid(out_valid3), .out_ready(out_ready3), .x(x3), .frame_cnt(cnt3));

  int tests = 0;
  int fails = 0;
  logic [N-1:0] sb [$];
  int exp_cnt = 0;
  int run = 0;
  int max_run = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pk(input logic a [N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[i];
    return r;
  endfunction

  function automatic logic [N3-1:0] pk8(input logic a [N3]);
    logic [N3-1:0] r;
    for (int i = 0; i < N3; i++) r[i] = a[i];
    return r;
  endfunction

  // Generator-matrix form: x[j] = XOR of u[i] over all i whose bits cover j.
  function automatic logic [N-1:0] model(input logic [N-1:0] uu, input logic rev);
    logic [N-1:0] y, r;
    y = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if ((i & j) == j) y[j] = y[j] ^ uu[i];
    for (int k = 0; k < N; k++) r[k] = rev ? y[((k & 1) << 1) | (k >> 1)] : y[k];
    return r;
  endfunction

  task automatic set_u(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) u[i] = v[i];
  endtask

  task automatic send(input logic [N-1:0] v, input logic r, input logic [N-1:0] exp);
    logic ok;
    ok = 1'b0;
    set_u(v);
    bit_rev  = r;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) sb.push_back(exp);
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    set_u('0);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 60; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    if (k == 60) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle();
    repeat (n) @(posedge clk);
    #1;
    sb.delete();
    exp_cnt = 0;
    run     = 0;
    rst_n   = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: got x %0h expected no frame", pk(x));
        end else begin
          check("x", 32'(pk(x)), 32'(sb.pop_front()));
        end
        check("frame_cnt_hs", 32'(frame_cnt), 32'(exp_cnt));
        exp_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [N-1:0] snap;
    for (int i = 0; i < N; i++) u[i] = 1'b0;
    for (int i = 0; i < N3; i++) u3[i] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_x", 32'(pk(x)), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid3", 32'(out_valid3), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulses, natural order, plus latency
    send(4'b0001, 1'b0, 4'b0001);
    idle();
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency_n2", 32'(lat), 2);
    drain();
    send(4'b0010, 1'b0, 4'b0011);
    send(4'b1000, 1'b0, 4'b1111);
    idle();
    drain();

    // Per-frame bit-reversed mode
    send(4'b0010, 1'b1, 4'b0101);
    send(4'b0010, 1'b0, 4'b0011);
    idle();
    drain();

    // Exhaustive back-to-back stream
    do_reset(1);
    max_run = 0;
    for (int v = 0; v < 16; v++) send(4'(v), 1'b0, model(4'(v), 1'b0));
    idle();
    drain();
    check("stream_run", 32'(max_run), 16);
    check("stream_frame_cnt", 32'(frame_cnt), 16);

    // Backpressure: 3-cycle stall once the first frame is out
    fork
      begin
        send(4'h9, 1'b0, model(4'h9, 1'b0));
        send(4'h6, 1'b1, model(4'h6, 1'b1));
        send(4'hC, 1'b0, model(4'hC, 1'b0));
        send(4'h5, 1'b0, model(4'h5, 1'b0));
        idle();
      end
      begin
        for (int k = 0; k < 20 && !out_valid; k++) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        snap = pk(x);
        check("stall_snap", 32'(snap), 32'(model(4'h9, 1'b0)));
        repeat (3) begin
          @(negedge clk);
          check("stall_out_valid", 32'(out_valid), 1);
          check("stall_x", 32'(pk(x)), 32'(snap));
          check("stall_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_frame_cnt", 32'(frame_cnt), 20);

    // Reset while frames are in flight
    send(4'b0001, 1'b0, 4'b0001);
    set_u(4'b1000);
    in_valid = 1'b1;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    idle();
    sb.delete();
    exp_cnt = 0;
    rst_n   = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_frame_cnt", 32'(frame_cnt), 0);
    check("midrst_x", 32'(pk(x)), 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_out", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(4'b0010, 1'b1, 4'b0101);
    idle();
    drain();

    // Counter wrap on the 4-bit instance: 17 handshakes since reset
    for (int v = 0; v < 16; v++) send(4'(v), v[0], model(4'(v), v[0]));
    idle();
    drain();
    check("main_cnt_17", 32'(frame_cnt), 17);
    check("wrap_cnt4", 32'(w_cnt), 1);

    // LOG_N = 3: u[7] only gives all ones after 3 edges
    u3[7]     = 1'b1;
    in_valid3 = 1'b1;
    @(negedge clk);
    check("n3_in_ready", 32'(in_ready3), 1);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    u3[7]     = 1'b0;
    lat = 1;
    while (!out_valid3 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency_n3", 32'(lat), 3);
    check("n3_x", 32'(pk8(x3)), 32'hFF);
    @(posedge clk); #1;
    check("n3_single_frame", 32'(out_valid3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/polar_transform_pipe.md
Name: polar_transform_pipe

Overview:
- Fully pipelined, parametrised polar encoder core. Computes x = u·F^{⊗n}, with F = [[1,0],[1,1]], for N = 2**LOG_N bits.
- Successor to the single-word polar transform. Adds:
  - one butterfly stage per register, giving 1 frame/cycle throughput;
  - valid/ready backpressure on input and output;
  - a per-frame bit-reversed output mode;
  - synchronous active-low reset;
  - an output frame counter.
- Sits between frozen-bit insertion (upstream) and modulation/channel model (downstream).

Parameters:
- LOG_N, 2, log2 of block length; legal range 1..10.
- BITS, 2**LOG_N, block length N. Derived; must not be overridden.
- CNT_W, 16, width of the output frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  u and bit_rev are valid this cycle.
- in_ready  out  1  core can accept a frame this cycle.
- u  in  BITS (unpacked logic u[BITS])  message/frozen vector; u[0] is first.
- bit_rev  in  1  output mode for this frame; 1 = bit-reversed order.
- out_valid  out  1  x holds a finished codeword.
- out_ready  in  1  downstream accepts x this cycle.
- x  out  BITS (unpacked logic x[BITS])  codeword.
- frame_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (rst_n == 0 sampled at a clk edge):
  - all stage valid bits, out_valid and frame_cnt go to 0; x = all 0.
  - Stage data registers are also cleared to 0.
  - Any frames in flight are discarded, with no partial output.
- Pipeline: LOG_N register stages, s = 0..LOG_N-1.
  - Stage s, for each i with bit s of i == 0 and h = 2**s: y[i] = v[i] ^ v[i+h]; y[i+h] = v[i+h].
  - Stage 0 input is u; stage LOG_N-1 output drives x.
- Advance enable: en = !out_valid || out_ready.
  - The whole pipeline shifts when en = 1 and holds every register when en = 0.
  - in_ready = en. This is combinational from out_ready and intentional.
- Acceptance occurs on in_valid && in_ready.
  - When en = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- Latency: a frame accepted at edge t appears with out_valid = 1 after edge t+LOG_N-1, provided there are no stalls. Each stall cycle adds 1.
- Throughput: one frame per cycle while out_ready = 1.
- bit_rev is captured with u and travels down the pipeline in its own per-stage bit.
  - At the final stage: x[i] = y[bitrev_LOG_N(i)] if the captured bit is 1, else x[i] = y[i].
  - The reorder is pure wiring and a mux in front of the last register; it adds no cycle.
- Output hold: while out_valid && !out_ready, x and out_valid stay stable. Output valid/ready protocol follows the AXI-stream convention.
- frame_cnt increments by 1 on each out_valid && out_ready edge and wraps modulo 2**CNT_W.
- Simultaneous output handshake and new input: both occur in the same cycle and no bubble is inserted.
- Reset asserted mid-stall: reset wins; out_valid is 0 on the next cycle regardless of out_ready.
- in_valid held high with unchanged u for k accepted cycles produces k output frames. The core does no deduplication.

Decomposition:
- Package polar_pkg holds:
  - LOG_N_MAX = 10;
  - function bitrev(idx, nbits);
  - typedef for the frame-count type (parametrised via CNT_W at use sites).
- Sub-module polar_butterfly_stage #(LOG_N, STAGE):
  - combinational XOR network for one stage, plus its data and valid/bit_rev registers and en input.
- The top generate-loops LOG_N instances and owns the handshake, reorder mux and frame_cnt.

Test Plan:
- Default LOG_N = 2. u given as u[0..3], x as x[0..3].
- Impulse/natural order, bit_rev = 0, out_ready = 1:
  - u = 1,0,0,0 -> x = 1,0,0,0.
  - u = 0,1,0,0 -> x = 1,1,0,0.
  - u = 0,0,0,1 -> x = 1,1,1,1.
  - Each x appears 2 edges after acceptance.
- Bit-reversed mode: u = 0,1,0,0 with bit_rev = 1 -> x = 1,0,1,0. Next frame u = 0,1,0,0, bit_rev = 0 -> x = 1,1,0,0, showing the mode is carried per frame.
- Exhaustive streaming:
  - all 16 u values on 16 consecutive cycles -> 16 consecutive out_valid cycles;
  - each x equals the software model u·F^{⊗2};
  - frame_cnt = 16 at the end.
- Backpressure:
  - stream 4 frames, drop out_ready for 3 cycles once out_valid = 1;
  - x and out_valid are held stable and in_ready = 0 during the stall;
  - no frame is lost or duplicated; order is preserved.
- Reset mid-flight: accept 2 frames, assert rst_n = 0 for 1 cycle before either emerges -> out_valid stays 0, frame_cnt = 0, x = 0; a new frame afterwards emerges normally.
- Wrap and size:
  - CNT_W = 4, 17 handshakes -> frame_cnt = 1;
  - LOG_N = 3 with u[7] = 1 only -> x = all 1s, latency 3.
